// File: rtl/data_bus_responder_if.sv
// M-stage data port bundle between the pipelined core and its data-side responder.
// Combinational response: ReadDataM answers ALUOutM within the same cycle.
// No backpressure: every access completes in the cycle it is presented.
//
// Signals:
//   MemWriteM   core -> responder  store strobe
//   ALUOutM     core -> responder  byte address
//   WriteDataM  core -> responder  store data
//   ReadDataM   responder -> core  load data
interface data_bus_responder_if;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;

  modport master (
    output MemWriteM,
    output ALUOutM,
    output WriteDataM,
    input  ReadDataM
  );

  modport slave (
    input  MemWriteM,
    input  ALUOutM,
    input  WriteDataM,
    output ReadDataM
  );
endinterface

// File: rtl/data_bus_responder.sv
// Memory-stage data responder: word RAM, MMIO timer/status/LED block, unmapped trap.
// Latency: loads are combinational (same cycle), stores commit on the next clk edge.
// Backpressure: none; every access is accepted and completed in the cycle it appears.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous active-low reset (0 = reset)
//   bus         data port (slave side): MemWriteM/ALUOutM/WriteDataM in, ReadDataM out
//   LedOut      MMIO LED register
//   TimerMatch  sticky compare-match flag (STATUS bit0)
//   BusError    sticky bad-store flag (STATUS bit1)
//
// Build option: define DBUS_TIMER_EN to include the COUNT/COMPARE timer and TimerMatch.
// Without it, MMIO offsets 0/1 read 0, stores to them are silently dropped and
// TimerMatch is tied low.
module data_bus_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  data_bus_responder_if.slave   bus,
  output logic [31:0]           LedOut,
  output logic                  TimerMatch,
  output logic                  BusError
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] OFF_COUNT   = 2'd0;
  localparam logic [1:0] OFF_COMPARE = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_LED     = 2'd3;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          aligned;
  logic          ram_hit;
  logic          mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [1:0]    mmio_off;

  assign addr     = bus.ALUOutM;
  assign wdata    = bus.WriteDataM;
  assign aligned  = (addr[1:0] == 2'b00);
  // RAM occupies 0..4*DEPTH-1: every bit above the word index must be zero.
  assign ram_hit  = aligned && (addr[31:AW+2] == '0);
  assign mmio_hit = aligned && (addr[31:4] == MMIO_BASE[31:4]);
  assign ram_idx  = addr[AW+1:2];
  assign mmio_off = addr[3:2];

  // Stores are ignored entirely while reset is held, so reset wins every collision.
  logic wr_en;
  logic ram_we;
  logic mmio_we;
  logic bad_wr;
  logic wr_status;
  logic wr_led;

  assign wr_en     = bus.MemWriteM && reset;
  assign ram_we    = wr_en && ram_hit;
  assign mmio_we   = wr_en && mmio_hit;
  assign bad_wr    = wr_en && !ram_hit && !mmio_hit;
  assign wr_status = mmio_we && (mmio_off == OFF_STATUS);
  assign wr_led    = mmio_we && (mmio_off == OFF_LED);

  // ---------------------------------------------------------------------------
  // Word RAM (contents survive reset)
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_idx] <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Timer
  // ---------------------------------------------------------------------------
  logic [31:0] count_rd;
  logic [31:0] compare_rd;
  logic        match_set;
  logic        match_flag;

`ifdef DBUS_TIMER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          match_q, match_d;
  logic          tick;
  logic [31:0]   count_inc;
  logic          wr_count;
  logic          wr_compare;

  assign wr_count   = mmio_we && (mmio_off == OFF_COUNT);
  assign wr_compare = mmio_we && (mmio_off == OFF_COMPARE);
  assign tick       = (pre_q == PRE_LAST);
  assign count_inc  = count_q + 32'd1;

  always_comb begin
    pre_d     = tick ? '0 : pre_q + PW'(1);
    count_d   = tick ? count_inc : count_q;
    compare_d = compare_q;
    // Match is judged against the compare value held before this edge, so a
    // same-edge COMPARE store only affects later ticks.
    match_set = tick && (count_inc == compare_q);
    if (wr_count) begin
      // A software COUNT store overrides the tick and restarts the prescaler.
      count_d   = wdata;
      pre_d     = '0;
      match_set = 1'b0;
    end
    if (wr_compare) begin
      compare_d = wdata;
    end
  end

  always_comb begin
    match_d = match_q;
    if (wr_status && wdata[0]) begin
      match_d = 1'b0;
    end
    // Set beats the write-1-to-clear on the same edge.
    if (match_set) begin
      match_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q     <= '0;
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      match_q   <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
    end
  end

  assign count_rd   = count_q;
  assign compare_rd = compare_q;
  assign match_flag = match_q;
`else
  assign count_rd   = '0;
  assign compare_rd = '0;
  assign match_set  = 1'b0;
  assign match_flag = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // LED and BusError
  // ---------------------------------------------------------------------------
  logic [31:0] led_q, led_d;
  logic        berr_q, berr_d;

  always_comb begin
    led_d  = led_q;
    berr_d = berr_q;
    if (wr_led) begin
      led_d = wdata;
    end
    if (wr_status && wdata[1]) begin
      berr_d = 1'b0;
    end
    // A dropped store sets the flag even when a clear lands on the same edge.
    if (bad_wr) begin
      berr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q  <= '0;
      berr_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      berr_q <= berr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational load path
  // ---------------------------------------------------------------------------
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (reset) begin
      if (ram_hit) begin
        rdata = mem_q[ram_idx];
      end else if (mmio_hit) begin
        case (mmio_off)
          OFF_COUNT:   rdata = count_rd;
          OFF_COMPARE: rdata = compare_rd;
          OFF_STATUS:  rdata = {30'b0, berr_q, match_flag};
          OFF_LED:     rdata = led_q;
          default:     rdata = '0;
        endcase
      end
    end
  end

  assign bus.ReadDataM = rdata;
  assign LedOut        = led_q;
  assign TimerMatch    = match_flag;
  assign BusError      = berr_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: RAM, decode errors, LED, timer, reset.
// Inputs change 1 time unit after a rising edge; loads are sampled 1 unit later.
// Expected load data goes through a queue (pushed at drive, popped at sample).
module tb_data_bus_responder;
  localparam int          DEPTH    = 1024;
  localparam logic [31:0] MB       = 32'hFFFF_0000;
  localparam logic [31:0] A_COUNT  = MB;
  localparam logic [31:0] A_CMP    = MB + 32'd4;
  localparam logic [31:0] A_STATUS = MB + 32'd8;
  localparam logic [31:0] A_LED    = MB + 32'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] LedOut;
  logic        TimerMatch;
  logic        BusError;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];
  logic [31:0] model [int];

  data_bus_responder_if bus ();

  data_bus_responder #(
    .DEPTH(DEPTH), .MMIO_BASE(MB), .PRESCALE(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .LedOut(LedOut), .TimerMatch(TimerMatch), .BusError(BusError)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.MemWriteM  = we;
    bus.ALUOutM    = a;
    bus.WriteDataM = d;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, a, d);
    if (reset && a[1:0] == 2'b00 && a < 32'(4 * DEPTH)) model[int'(a >> 2)] = d;
    @(posedge clk); #1;
    drive(1'b0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    bus.MemWriteM = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [31:0] got, exp;
    exp_q.push_back(32'h0);
    drive(1'b0, A_LED, 32'h0);
    #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL reset_read got=%h want=%h", got, exp); end
    total++;
    if ({LedOut, TimerMatch, BusError} !== 34'h0) begin
      bad++; $display("FAIL reset_state got led=%h tm=%b be=%b want 0", LedOut, TimerMatch, BusError);
    end
    reset = 1'b1;
  endtask

  task automatic test_ram;
    logic [31:0] got, exp;
    logic [31:0] la [3];
    la = '{32'h10, 32'h14, 32'(4 * DEPTH - 4)};
    store(32'h14, 32'h1111_1111);
    store(32'h10, 32'hDEAD_BEEF);
    store(32'(4 * DEPTH - 4), 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model[int'(la[i] >> 2)]);
      drive(1'b0, la[i], 32'h0);
      #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL ram_load[%0d] got=%h want=%h", i, got, exp); end
      @(posedge clk); #1;
    end
    exp_q.push_back(32'h0);
    drive(1'b0, 32'(4 * DEPTH), 32'h0);
    #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL unmapped_load got=%h want=%h", got, exp); end
    idle(1);
    total++;
    if (BusError !== 1'b0) begin bad++; $display("FAIL load_no_flag got=%b want=0", BusError); end
  endtask

  task automatic test_bus_error;
    logic [31:0] got, exp;
    store(32'h0, 32'h0000_0AAA);
    store(32'h11, 32'hBAD0_BAD0);
    total++;
    if (BusError !== 1'b1) begin bad++; $display("FAIL berr_misaligned got=%b want=1", BusError); end
    store(A_STATUS, 32'h2);
    total++;
    if (BusError !== 1'b0) begin bad++; $display("FAIL berr_w1c got=%b want=0", BusError); end
    store(32'h0001_0000, 32'hBAD1_BAD1);
    total++;
    if (BusError !== 1'b1) begin bad++; $display("FAIL berr_unmapped got=%b want=1", BusError); end
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'h0000_0AAA);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h0);
    drive(1'b0, 32'h10, 32'h0);
    #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL ram_0x10_kept got=%h want=%h", got, exp); end
    drive(1'b0, 32'h0, 32'h0);
    #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL ram_0x0_kept got=%h want=%h", got, exp); end
    drive(1'b0, A_STATUS, 32'h0);
    #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL status_read got=%h want=%h", got, exp); end
    drive(1'b0, MB + 32'h10, 32'h0);
    #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL past_mmio_load got=%h want=%h", got, exp); end
    store(A_STATUS, 32'h1);
    total++;
    if (BusError !== 1'b1) begin bad++; $display("FAIL w1c_other_bit got=%b want=1", BusError); end
    store(A_STATUS, 32'h2);
    store(MB + 32'hE, 32'h5);
    total++;
    if (BusError !== 1'b1 || LedOut !== 32'h0) begin
      bad++; $display("FAIL mmio_misaligned got be=%b led=%h want be=1 led=0", BusError, LedOut);
    end
    store(A_STATUS, 32'h2);
  endtask

  task automatic test_led;
    logic [31:0] got, exp;
    store(A_LED, 32'h0000_00A5);
    total++;
    if (LedOut !== 32'hA5) begin bad++; $display("FAIL led_out got=%h want=000000a5", LedOut); end
    exp_q.push_back(32'hA5);
    drive(1'b0, A_LED, 32'h0);
    #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL led_read got=%h want=%h", got, exp); end
    idle(1);
  endtask

  task automatic test_back_to_back;
    logic [31:0] got, exp;
    logic [31:0] a;
    for (int i = 0; i < 8; i++) store(32'h40 + 32'(4 * i), $urandom);
    for (int i = 0; i < 8; i++) begin
      a = 32'h40 + 32'(4 * i);
      exp_q.push_back(model[int'(a >> 2)]);
      drive(1'b0, a, 32'h0);
      #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL b2b_load[%0d] got=%h want=%h", i, got, exp); end
      @(posedge clk); #1;
    end
    // Store immediately followed by load of the same word, alternating.
    for (int i = 0; i < 4; i++) begin
      a = 32'h80 + 32'(4 * i);
      store(a, 32'h5A00_0000 + 32'(i));
      exp_q.push_back(32'h5A00_0000 + 32'(i));
      drive(1'b0, a, 32'h0);
      #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL st_ld[%0d] got=%h want=%h", i, got, exp); end
    end
    idle(1);
  endtask

`ifdef DBUS_TIMER_EN
  task automatic test_timer;
    logic [31:0] got, exp;
    logic [31:0] cexp [3];
    cexp = '{32'h1, 32'h1, 32'h2};
    // Fresh reset so the prescaler phase is known.
    reset = 1'b0; @(posedge clk); #1; reset = 1'b1;
    drive(1'b0, A_COUNT, 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle(i == 0 ? 4 : (i == 1 ? 3 : 1));
      exp_q.push_back(cexp[i]);
      drive(1'b0, A_COUNT, 32'h0);
      #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL timer_count[%0d] got=%h want=%h", i, got, exp); end
    end
  endtask

  task automatic test_match;
    logic [31:0] got, exp;
    reset = 1'b0; @(posedge clk); #1; reset = 1'b1;
    store(A_CMP, 32'h3);
    idle(10);
    total++;
    if (TimerMatch !== 1'b0) begin bad++; $display("FAIL match_early got=%b want=0", TimerMatch); end
    idle(1);
    total++;
    if (TimerMatch !== 1'b1) begin bad++; $display("FAIL match_rise got=%b want=1", TimerMatch); end
    exp_q.push_back(32'h1);
    drive(1'b0, A_STATUS, 32'h0);
    #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL match_status got=%h want=%h", got, exp); end
    store(A_STATUS, 32'h1);
    store(A_COUNT, 32'h2);
    idle(3);
    total++;
    if (TimerMatch !== 1'b0) begin bad++; $display("FAIL match_cleared got=%b want=0", TimerMatch); end
    store(A_STATUS, 32'h1);
    total++;
    if (TimerMatch !== 1'b1) begin bad++; $display("FAIL set_beats_w1c got=%b want=1", TimerMatch); end
    store(A_STATUS, 32'h1);
    store(A_COUNT, 32'h0);
    idle(3);
    store(A_CMP, 32'h1);
    total++;
    if (TimerMatch !== 1'b0) begin bad++; $display("FAIL old_compare got=%b want=0", TimerMatch); end
    exp_q.push_back(32'h1);
    drive(1'b0, A_COUNT, 32'h0);
    #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL count_after_tick got=%h want=%h", got, exp); end
  endtask

  task automatic test_wrap;
    logic [31:0] got, exp;
    logic [31:0] wexp [4];
    int          wgap [4];
    wexp = '{32'hFFFF_FFFF, 32'h0, 32'h100, 32'h101};
    wgap = '{3, 1, 3, 1};
    store(A_COUNT, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        idle(3);
        store(A_COUNT, 32'h100); // lands on the tick edge
      end
      idle(wgap[i]);
      exp_q.push_back(wexp[i]);
      drive(1'b0, A_COUNT, 32'h0);
      #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL wrap_count[%0d] got=%h want=%h", i, got, exp); end
    end
    total++;
    if (TimerMatch !== 1'b0) begin bad++; $display("FAIL wrap_no_match got=%b want=0", TimerMatch); end
  endtask
`else
  task automatic test_timer_disabled;
    logic [31:0] got, exp;
    store(A_COUNT, 32'h55);
    store(A_CMP, 32'h1);
    total++;
    if (BusError !== 1'b0) begin bad++; $display("FAIL notimer_no_berr got=%b want=0", BusError); end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    drive(1'b0, A_COUNT, 32'h0);
    #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL notimer_count got=%h want=%h", got, exp); end
    drive(1'b0, A_CMP, 32'h0);
    #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL notimer_cmp got=%h want=%h", got, exp); end
    idle(20);
    total++;
    if (TimerMatch !== 1'b0) begin bad++; $display("FAIL notimer_match got=%b want=0", TimerMatch); end
  endtask
`endif

  task automatic test_reset_mid;
    logic [31:0] got, exp;
    store(A_LED, 32'hA5);
    store(32'h3, 32'h0);
`ifdef DBUS_TIMER_EN
    store(A_COUNT, 32'h5);
    store(A_CMP, 32'h6);
    idle(3);
`endif
    total++;
    if (LedOut !== 32'hA5 || BusError !== 1'b1) begin
      bad++; $display("FAIL pre_reset got led=%h be=%b want led=000000a5 be=1", LedOut, BusError);
    end
`ifdef DBUS_TIMER_EN
    total++;
    if (TimerMatch !== 1'b1) begin bad++; $display("FAIL pre_reset_match got=%b want=1", TimerMatch); end
`endif
    // Reset edge coincides with an LED store: reset must win.
    drive(1'b1, A_LED, 32'h77);
    reset = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(32'h0);
    drive(1'b0, A_LED, 32'h0);
    #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL read_in_reset got=%h want=%h", got, exp); end
    total++;
    if ({LedOut, TimerMatch, BusError} !== 34'h0) begin
      bad++; $display("FAIL mid_reset got led=%h tm=%b be=%b want 0", LedOut, TimerMatch, BusError);
    end
    reset = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(model[4]);
    drive(1'b0, A_COUNT, 32'h0);
    #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL count_after_reset got=%h want=%h", got, exp); end
    drive(1'b0, 32'h10, 32'h0);
    #1; got = bus.ReadDataM; exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL ram_retained got=%h want=%h", got, exp); end
    idle(1);
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_ram;
    test_bus_error;
    test_led;
`ifdef DBUS_TIMER_EN
    test_timer;
    test_match;
    test_wrap;
`else
    test_timer_disabled;
`endif
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
